submean_ch_sched: RTL

Round-robin scheduler that time-multiplexes NUM_CH microphone sample streams into one shared mean-subtraction datapath in the beamforming front end. It buffers one sample per channel and issues channel-tagged beats to the datapath over a valid/ready handshake. It tracks each channel's window warm-up and flags when the datapath output for that channel is meaningful. It also sequences a per-channel clear of the datapath accumulators on flush.

---
 rtl/submean_ch_sched_pkg.sv | 20 ++
 rtl/submean_ch_sched_rr_arbiter.sv | 36 +++
 rtl/submean_ch_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/submean_ch_sched_pkg.sv
// Shared constants and helpers for the mean-subtraction channel scheduler.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
// Contents: scheduler state encodings, clog2 used for CH_W and warm-counter widths.
package submean_sched_pkg;

  // Scheduler states, kept as plain constants so the encoding is visible in waves.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/submean_ch_sched_rr_arbiter.sv
// Rotating-priority encoder: first requester after last_grant, wrapping modulo NUM_CH.
// Latency: purely combinational.
// Backpressure: en gates the grant; requests are not consumed here.
// Ports: req (per-channel request), last_grant, en -> gnt_valid, gnt_idx.
module rr_arbiter
  import submean_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  input  logic              en,
  output logic              gnt_valid,
  output logic [CH_W-1:0]   gnt_idx
);

  logic            w_found;
  logic [CH_W-1:0] w_pos;

  // Walk offsets 1..NUM_CH so last_grant itself is checked last.
  always_comb begin
    w_found = 1'b0;
    gnt_idx = '0;
    w_pos   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_pos = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        gnt_idx = w_pos;
      end
    end
    gnt_valid = en && w_found;
  end

endmodule

// File: rtl/submean_ch_sched.sv
// Round-robin scheduler feeding NUM_CH single-sample slots into one mean-subtraction datapath.
// Latency: sample captured on edge k can be issued after edge k+1; worst case NUM_CH beats.
// Backpressure: dp_valid/dp_data/dp_ch/dp_warm hold while dp_valid && !dp_ready; a second
//   sample on a still-pending channel overwrites its slot and sets the sticky overrun flag.
// Ports: clk, reset (async, active-high); ch_valid/ch_data per-channel inputs; flush and
//   overrun_clr controls; dp_valid/dp_ready/dp_data/dp_ch/dp_warm beat interface;
//   dp_clear accumulator-clear pulse; overrun sticky flags; busy during DRAIN/FLUSH.
module submean_ch_sched
  import submean_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 16,
  parameter int CH_W        = clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         flush,
  input  logic                         overrun_clr,
  output logic                         dp_valid,
  input  logic                         dp_ready,
  output logic [DATA_WIDTH-1:0]        dp_data,
  output logic [CH_W-1:0]              dp_ch,
  output logic                         dp_warm,
  output logic                         dp_clear,
  output logic [NUM_CH-1:0]            overrun,
  output logic                         busy
);

  localparam int              WC_W    = clog2(WINDOW_SIZE) + 1;
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(WINDOW_SIZE);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [1:0]            r_state;
  logic [CH_W-1:0]       r_clr_idx;
  logic [CH_W-1:0]       r_last_grant;
  logic [NUM_CH-1:0]     r_pending;
  logic [NUM_CH-1:0]     r_overrun;
  logic [DATA_WIDTH-1:0] r_slot [NUM_CH];
  logic [WC_W-1:0]       r_wcnt [NUM_CH];
  logic                  r_dp_valid;
  logic [DATA_WIDTH-1:0] r_dp_data;
  logic [CH_W-1:0]       r_dp_ch;
  logic                  r_dp_warm;

  logic                  w_load;
  logic                  w_arb_en;
  logic                  w_gnt_valid;
  logic [CH_W-1:0]       w_gnt_idx;
  logic [NUM_CH-1:0]     w_gnt_hot;
  logic [NUM_CH-1:0]     w_capture;
  logic [NUM_CH-1:0]     w_ovr_set;

  // Output register is free when empty or its current beat is being taken.
  assign w_load   = !r_dp_valid || dp_ready;
  // A flush arriving in RUN already blocks the grant on its own edge.
  assign w_arb_en = (r_state == ST_RUN) && !flush && w_load;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req        (r_pending),
    .last_grant (r_last_grant),
    .en         (w_arb_en),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  always_comb begin
    w_gnt_hot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_gnt_hot[i] = w_gnt_valid && (w_gnt_idx == CH_W'(i));
    end
    // Samples arriving during FLUSH are dropped and counted as lost.
    w_capture = (r_state == ST_FLUSH) ? '0 : ch_valid;
    // A granted channel hands its old sample out on this edge, so a new one is not a loss.
    w_ovr_set = ch_valid & ((r_state == ST_FLUSH) ? {NUM_CH{1'b1}} : (r_pending & ~w_gnt_hot));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_clr_idx    <= '0;
      r_last_grant <= LAST_CH;
      r_pending    <= '0;
      r_overrun    <= '0;
      r_dp_valid   <= 1'b0;
      r_dp_data    <= '0;
      r_dp_ch      <= '0;
      r_dp_warm    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_slot[i] <= '0;
        r_wcnt[i] <= '0;
      end
    end else begin
      // A fresh loss on the same edge as the clear keeps its flag.
      r_overrun <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;

      for (int i = 0; i < NUM_CH; i++) begin
        if (w_capture[i]) r_slot[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end

      if (r_state == ST_FLUSH && r_clr_idx == LAST_CH) begin
        r_pending <= '0;
      end else begin
        r_pending <= (r_pending & ~w_gnt_hot) | w_capture;
      end

      if (w_gnt_valid) begin
        r_dp_valid   <= 1'b1;
        r_dp_data    <= r_slot[w_gnt_idx];
        r_dp_ch      <= w_gnt_idx;
        r_dp_warm    <= (r_wcnt[w_gnt_idx] == WC_FULL);
        r_last_grant <= w_gnt_idx;
        if (r_wcnt[w_gnt_idx] != WC_FULL) begin
          r_wcnt[w_gnt_idx] <= r_wcnt[w_gnt_idx] + WC_W'(1);
        end
      end

      case (r_state)
        ST_RUN: begin
          if (w_load && !w_gnt_valid) r_dp_valid <= 1'b0;
          if (flush) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave only once the in-flight beat (if any) has been accepted.
          if (w_load) begin
            r_state    <= ST_FLUSH;
            r_clr_idx  <= '0;
            r_dp_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_wcnt[r_clr_idx] <= '0;
          if (r_clr_idx == LAST_CH) begin
            r_state <= ST_RUN;
          end else begin
            r_clr_idx <= r_clr_idx + CH_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign dp_valid = r_dp_valid;
  assign dp_data  = r_dp_data;
  assign dp_warm  = r_dp_warm;
  // During FLUSH the channel tag names the accumulator being cleared.
  assign dp_ch    = (r_state == ST_FLUSH) ? r_clr_idx : r_dp_ch;
  assign dp_clear = (r_state == ST_FLUSH);
  assign overrun  = r_overrun;
  assign busy     = (r_state != ST_RUN);

endmodule
